// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq
//   Reset sequencer for the ECP5 EHXPLLL. Runs on the 25 MHz reference clock,
//   which is alive before the PLL locks. It pulses the PLL RST pin, waits for
//   lock, and requires LOCK_HOLD consecutive locked cycles before it releases
//   the system reset. Loss of lock in run puts the system back into reset
//   without re-pulsing the PLL. If lock never arrives, the PLL is re-pulsed
//   every LOCK_TIMEOUT cycles.
// Ports
//   clk           25 MHz reference clock (same net as the PLL input)
//   rst           synchronous active-high reset
//   pll_locked    raw PLL LOCK; asynchronous to clk
//   soft_rst      one-cycle request for a full PLL reset sequence
//   pll_rst       PLL RST pin drive, active high
//   rst_out       synchronous active-high system reset source
//   ready         high exactly while in S_RUN (always ~rst_out)
//   lock_lost_cnt lock losses seen in S_RUN, saturating at 255
module pll_lock_reset_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int PLLRST_CYCLES = 16,
  parameter int LOCK_HOLD     = 1024,
  parameter int LOCK_TIMEOUT  = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_rst,
  output logic       pll_rst,
  output logic       rst_out,
  output logic       ready,
  output logic [7:0] lock_lost_cnt
);

  localparam int MAX_AB = (PLLRST_CYCLES > LOCK_HOLD) ? PLLRST_CYCLES : LOCK_HOLD;
  localparam int MAX_C  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CW     = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] PR_LAST = CW'(PLLRST_CYCLES - 1);
  localparam logic [CW-1:0] LH_LAST = CW'(LOCK_HOLD - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_PLLRST    = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  // Plain flop chain: the only logic that ever sees pll_locked.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_PLLRST;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      rst_out       <= 1'b1;
      ready         <= 1'b0;
      lock_lost_cnt <= 8'd0;
    end else begin
      // A lock loss in run is counted even when soft_rst wins the transition.
      if (state == S_RUN && !locked_s && lock_lost_cnt != 8'hFF)
        lock_lost_cnt <= lock_lost_cnt + 8'd1;

      if (soft_rst) begin
        state   <= S_PLLRST;
        cnt     <= '0;
        pll_rst <= 1'b1;
        rst_out <= 1'b1;
        ready   <= 1'b0;
      end else begin
        case (state)
          S_PLLRST: begin
            if (cnt == PR_LAST) begin
              state   <= S_WAIT_LOCK;
              cnt     <= '0;
              pll_rst <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_WAIT_LOCK: begin
            if (locked_s) begin
              state <= S_STABLE;
              cnt   <= '0;
            end else if (cnt == TO_LAST) begin
              state   <= S_PLLRST;
              cnt     <= '0;
              pll_rst <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_STABLE: begin
            // Any dropout restarts the hold window from scratch.
            if (!locked_s) begin
              state <= S_WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == LH_LAST) begin
              state   <= S_RUN;
              cnt     <= '0;
              rst_out <= 1'b0;
              ready   <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_RUN: begin
            if (!locked_s) begin
              state   <= S_WAIT_LOCK;
              cnt     <= '0;
              rst_out <= 1'b1;
              ready   <= 1'b0;
            end
          end
          default: begin
            state   <= S_PLLRST;
            cnt     <= '0;
            pll_rst <= 1'b1;
            rst_out <= 1'b1;
            ready   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
